// File: rtl/bicubic_pkg.sv
// bicubic_pkg: shared types and constants for the bicubic output serializer
package bicubic_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int LANES = 4;
  typedef logic [1:0] lane_t;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  // quads are packed with lane 0 at the LSB, so emission runs FIRST_LANE..LAST_LANE
  localparam lane_t FIRST_LANE = 2'd0;
  localparam lane_t LAST_LANE = 2'd3;
endpackage

// File: rtl/bicubic_out_serializer_quad_fifo.sv
// quad_fifo: synchronous quad FIFO exposing the head entry and the entry behind it
module quad_fifo
  import bicubic_pkg::*;
#(
  parameter int W = LANES * DATA_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             head,
  output logic [W-1:0]             head_nx,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign head = mem[rptr];
  assign head_nx = mem[rptr + AW'(1)];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr + AW'(rd);
      count <= count + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wptr] <= wdata;
endmodule

// File: rtl/bicubic_out_serializer.sv
// bicubic_out_serializer: buffers 4-pixel quads and re-serialises them with sol/eol/eof markers.
// Define BICUBIC_SER_FRAME_CNT_EN to add a 16-bit frame_cnt output.
module bicubic_out_serializer
  import bicubic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 4,
  parameter int LINE_QUADS = 16,
  parameter int ROWS = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef BICUBIC_SER_FRAME_CNT_EN
  output logic [15:0]       frame_cnt,
`endif
  input  logic              act,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  output logic              full,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sol,
  output logic              eol,
  output logic              eof,
  output logic              overflow
);
  localparam int QW = LANES * DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int XW = LINE_QUADS > 1 ? $clog2(LINE_QUADS) : 1;
  localparam int YW = ROWS > 1 ? $clog2(ROWS) : 1;
  logic [QW-1:0] head, head_nx;
  logic [CW-1:0] count;
  logic empty, pop, valid_n, last_col, last_row, more;
  state_t state, state_n;
  lane_t lane, lane_n;
  logic [XW-1:0] col, col_n;
  logic [YW-1:0] row, row_n;
  logic [DATA_W-1:0] out_n;
  quad_fifo #(.W(QW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(act), .pop(pop),
    .wdata({in_3, in_2, in_1, in_0}),
    .head(head), .head_nx(head_nx), .count(count), .full(full), .empty(empty)
  );
  assign last_col = col == XW'(LINE_QUADS - 1);
  assign last_row = row == YW'(ROWS - 1);
  assign more = count > CW'(1);
  assign sol = out_valid && lane == FIRST_LANE && col == '0;
  assign eol = out_valid && lane == LAST_LANE && last_col;
  assign eof = eol && last_row;
  always_comb begin
    state_n = state;
    lane_n = lane;
    col_n = col;
    row_n = row;
    out_n = out;
    valid_n = out_valid;
    pop = 1'b0;
    if (state == IDLE) begin
      if (!empty) begin
        state_n = SEND;
        valid_n = 1'b1;
        lane_n = FIRST_LANE;
        out_n = head[DATA_W-1:0];
      end
    end else if (out_ready) begin
      if (lane != LAST_LANE) begin
        lane_n = lane + lane_t'(1);
        out_n = head[lane_n*DATA_W +: DATA_W];
      end else begin
        // the follow-on quad must already sit in memory to chain without a bubble
        pop = 1'b1;
        lane_n = FIRST_LANE;
        col_n = last_col ? '0 : col + XW'(1);
        row_n = !last_col ? row : last_row ? '0 : row + YW'(1);
        out_n = more ? head_nx[DATA_W-1:0] : out;
        valid_n = more;
        state_n = more ? SEND : IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      lane <= FIRST_LANE;
      col <= '0;
      row <= '0;
      out <= '0;
      out_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      lane <= lane_n;
      col <= col_n;
      row <= row_n;
      out <= out_n;
      out_valid <= valid_n;
      overflow <= overflow | (act & full);
    end
  end
`ifdef BICUBIC_SER_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) frame_cnt <= '0;
    else if (eof && out_ready) frame_cnt <= frame_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_bicubic_out_serializer.sv
// tb_bicubic_out_serializer: scoreboard bench for the quad serializer (LINE_QUADS=2, ROWS=2, DEPTH=4)
module tb_bicubic_out_serializer;
  localparam int LQ = 2;
  localparam int RW = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic act = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0;
  logic full, out_valid, sol, eol, eof, overflow;
  logic [7:0] out;
`ifdef BICUBIC_SER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif
  int total = 0;
  int bad = 0;
  int pq = 0;
  int xfers = 0;
  int eofs = 0;
  logic [10:0] sb[$];
  logic [10:0] exp_v, got_v;

  bicubic_out_serializer #(.DATA_W(8), .DEPTH(4), .LINE_QUADS(LQ), .ROWS(RW)) dut (
    .clk(clk), .rst(rst),
`ifdef BICUBIC_SER_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .act(act), .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .full(full), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .sol(sol), .eol(eol), .eof(eof), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // expected {eof,eol,sol,pixel} for lane l of the q-th accepted quad since reset
  function automatic logic [10:0] exp_px(int q, int l, logic [7:0] p);
    int col = q % LQ;
    int row = (q / LQ) % RW;
    logic s = (l == 0) && (col == 0);
    logic e = (l == 3) && (col == LQ - 1);
    return {e && (row == RW - 1), e, s, p};
  endfunction

  task automatic expect_quad(input logic [7:0] a, b, c, d);
    sb.push_back(exp_px(pq, 0, a));
    sb.push_back(exp_px(pq, 1, b));
    sb.push_back(exp_px(pq, 2, c));
    sb.push_back(exp_px(pq, 3, d));
    pq++;
  endtask

  task automatic push_quad(input logic [7:0] a, b, c, d);
    for (int t = 0; t < 200 && full; t++) begin @(posedge clk); #1; end
    act = 1'b1; in_0 = a; in_1 = b; in_2 = c; in_3 = d;
    expect_quad(a, b, c, d);
    @(posedge clk); #1;
    act = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    pq = 0;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      xfers++;
      total++;
      got_v = {eof, eol, sol, out};
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL stream_extra got=%h required none", got_v);
      end else begin
        exp_v = sb.pop_front();
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL stream_pixel got {eof,eol,sol,px}=%h required %h", got_v, exp_v);
        end
      end
      if (eof) eofs++;
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if ({out_valid, full, overflow, sol, eol, eof} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b required 000000", {out_valid, full, overflow, sol, eol, eof});
    end
    total++;
    if (out !== 8'h00) begin bad++; $display("FAIL reset_out got=%h required 00", out); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    act = 1'b1; in_0 = 8'h10; in_1 = 8'h20; in_2 = 8'h30; in_3 = 8'h40;
    expect_quad(8'h10, 8'h20, 8'h30, 8'h40);
    @(posedge clk); #1;
    act = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_latency_early got=%b required 0", out_valid); end
    @(negedge clk);
    total++;
    if ({out_valid, sol, out} !== {1'b1, 1'b1, 8'h10}) begin
      bad++;
      $display("FAIL single_first got={v,sol,out}=%b_%b_%h required 1_1_10", out_valid, sol, out);
    end
    for (int t = 0; t < 50 && sb.size() != 0; t++) begin @(posedge clk); #1; end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL single_drain got=%0d left required 0", sb.size()); end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b required 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int x0 = xfers;
    out_ready = 1'b1;
    push_quad(8'h10, 8'h20, 8'h30, 8'h40);
    for (int t = 0; t < 20 && !(out_valid && out == 8'h30); t++) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out} !== {1'b1, 8'h30}) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got={v,out}=%b_%h required 1_30", i, out_valid, out);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && sb.size() != 0; t++) begin @(posedge clk); #1; end
    total++;
    if (xfers - x0 != 4) begin bad++; $display("FAIL bp_count got=%0d required 4", xfers - x0); end
  endtask

  task automatic test_markers();
    int e0;
    do_reset();
    e0 = eofs;
    out_ready = 1'b1;
    for (int q = 0; q < 5; q++) push_quad(8'(8'h80 + q*4), 8'(8'h81 + q*4), 8'(8'h82 + q*4), 8'(8'h83 + q*4));
    for (int t = 0; t < 100 && sb.size() != 0; t++) begin @(posedge clk); #1; end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL mark_drain got=%0d left required 0", sb.size()); end
    total++;
    if (eofs - e0 != 1) begin bad++; $display("FAIL mark_eof_count got=%0d required 1", eofs - e0); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL mark_overflow got=%b required 0", overflow); end
  endtask

  task automatic test_fill();
    int x0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      act = 1'b1; in_0 = 8'(8'h40 + i*4); in_1 = 8'(8'h41 + i*4); in_2 = 8'(8'h42 + i*4); in_3 = 8'(8'h43 + i*4);
      if (i < 4) expect_quad(in_0, in_1, in_2, in_3);
      @(posedge clk); #1;
      if (i == 2) begin
        total++;
        if (full !== 1'b0) begin bad++; $display("FAIL fill_3 got full=%b required 0", full); end
      end
      if (i == 3) begin
        total++;
        if (full !== 1'b1) begin bad++; $display("FAIL fill_4 got full=%b required 1", full); end
      end
    end
    act = 1'b0;
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL fill_overflow got=%b required 1", overflow); end
    x0 = xfers;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && sb.size() != 0; t++) begin @(posedge clk); #1; end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (xfers - x0 != 16) begin bad++; $display("FAIL fill_drain got=%0d pixels required 16", xfers - x0); end
    total++;
    if ({overflow, full} !== 2'b10) begin bad++; $display("FAIL fill_sticky got={ovf,full}=%b required 10", {overflow, full}); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    push_quad(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    push_quad(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    for (int t = 0; t < 20 && !(out_valid && out == 8'hA1); t++) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({out_valid, full, overflow, sol} !== 4'b0) begin
      bad++;
      $display("FAIL rmid_state got={v,full,ovf,sol}=%b required 0000", {out_valid, full, overflow, sol});
    end
    sb.delete();
    pq = 0;
    rst = 1'b1;
    push_quad(8'h55, 8'h66, 8'h77, 8'h88);
    for (int t = 0; t < 20 && !out_valid; t++) begin @(posedge clk); #1; end
    total++;
    if ({out_valid, sol, out} !== {1'b1, 1'b1, 8'h55}) begin
      bad++;
      $display("FAIL rmid_first got={v,sol,out}=%b_%b_%h required 1_1_55", out_valid, sol, out);
    end
    for (int t = 0; t < 50 && sb.size() != 0; t++) begin @(posedge clk); #1; end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL rmid_drain got=%0d left required 0", sb.size()); end
  endtask

`ifdef BICUBIC_SER_FRAME_CNT_EN
  task automatic test_frame_cnt();
    do_reset();
    out_ready = 1'b1;
    for (int q = 0; q < 12; q++) push_quad(8'(q), 8'(q + 1), 8'(q + 2), 8'(q + 3));
    for (int t = 0; t < 200 && sb.size() != 0; t++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    total++;
    if (frame_cnt !== 16'd3) begin bad++; $display("FAIL frame_cnt got=%0d required 3", frame_cnt); end
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_markers();
    test_fill();
    test_reset_mid();
`ifdef BICUBIC_SER_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bicubic_out_serializer.md
Name: bicubic_out_serializer

Overview:
- Back end of the bicubic upscaler; the inverse of the serial-to-parallel input_array at the front.
- Accepts the 4 interpolated 8-bit pixels the engine produces per active cycle and buffers them as quads in a small FIFO.
- Re-serialises the quads onto a single 8-bit valid/ready pixel stream, with line/frame markers for the downstream frame writer.

Parameters:
- DATA_W, 8, pixel width.
- DEPTH, 4, FIFO depth in quads; power of 2, minimum 2.
- LINE_QUADS, 16, quads per output line.
- ROWS, 16, output lines per frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- act  in  1  quad valid; sampled with in_0..in_3.
- in_0  in  DATA_W  pixel lane 0, emitted first.
- in_1  in  DATA_W  pixel lane 1.
- in_2  in  DATA_W  pixel lane 2.
- in_3  in  DATA_W  pixel lane 3, emitted last.
- full  out  1  FIFO holds DEPTH quads.
- out  out  DATA_W  serial pixel.
- out_valid  out  1  out holds a pixel.
- out_ready  in  1  downstream accepts.
- sol  out  1  start of line; qualified by out_valid.
- eol  out  1  end of line; qualified by out_valid.
- eof  out  1  end of frame; qualified by out_valid.
- overflow  out  1  sticky: a quad was dropped.

Behaviour:
- Reset: single clock clk; reset is synchronous and active-low on rst, sampled only at posedge clk.
  - While rst is 0 at an edge: FIFO count, read/write pointers, lane, col and row counters all go to 0; state goes to IDLE.
  - Outputs at reset: out=0, out_valid=0, sol=0, eol=0, eof=0, overflow=0, full=0.
  - Reset mid-transfer discards all buffered quads and the pixel in flight; no partial completion.
- Push:
  - At an edge with act=1 and full=0, {in_3,in_2,in_1,in_0} is written at wptr; wptr and count increment.
  - act=1 while full=1: the quad is dropped and overflow is set to 1. overflow stays 1 until reset.
  - full is evaluated from the registered count before any pop in the same cycle. A push in the same cycle as the final-lane pop is therefore rejected when full=1.
- Read FSM:
  - IDLE: if count>0, load out=lane 0 of the head quad, set out_valid=1, lane=0, and go to SEND.
  - SEND: a transfer occurs when out_valid=1 and out_ready=1.
    - Transfer on lane<3: lane increments and out loads the next lane in the next cycle. out_valid stays 1 with no bubble.
    - Transfer on lane=3: the head quad is popped (rptr+1, count-1). If count-after-pop>0, load lane 0 of the new head and stay in SEND; otherwise set out_valid=0 and go to IDLE.
  - While out_valid=1 and out_ready=0: out, sol, eol and eof are held stable.
  - A simultaneous push and pop leaves count unchanged.
- Latency: a quad sampled at edge N produces out_valid=1 after edge N+1 if the FIFO was empty and the FSM was in IDLE. Sustained throughput is 1 pixel/cycle, i.e. one quad per 4 cycles.
- Markers:
  - sol=1 on lane 0 when col=0.
  - eol=1 on lane 3 when col=LINE_QUADS-1.
  - eof=eol and row=ROWS-1.
  - col increments on each pop and wraps to 0 after LINE_QUADS-1, which increments row. row wraps to 0 after eof.
- Widths: count is clog2(DEPTH)+1 bits; pointers are clog2(DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: BICUBIC_SER_FRAME_CNT_EN.
- Defined: adds output port frame_cnt (16 bits). It is 0 at reset and increments on each transferred eof pixel, wrapping from 0xFFFF to 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package bicubic_pkg: DATA_W default, lane index type (2 bits), FSM state encoding (IDLE=0, SEND=1), quad packing order constant (lane 0 at LSB).
- One sub-module: quad_fifo. It is a synchronous FIFO with push, pop, count and full/empty, holding 4*DATA_W-bit entries. The serializer FSM and the line/frame counters stay in the top.

Test Plan:
- Single quad 0x10,0x20,0x30,0x40 with out_ready=1 -> out_valid rises after edge N+1; out reads 10,20,30,40 on consecutive cycles with sol=1 on 0x10; then out_valid=0.
- Backpressure: out_ready=0 for 5 cycles during lane 2 -> out holds 0x30 with out_valid=1; resumes with 0x40; no pixel lost or duplicated.
- Fill: 5 quads on back-to-back act with out_ready=0 and DEPTH=4 -> full=1 after the 4th; 5th dropped; overflow=1 and stays 1; exactly 16 pixels drain when out_ready is raised.
- Frame markers with LINE_QUADS=2, ROWS=2 and 4 quads streamed -> eol on pixels 8 and 16; eof only on pixel 16; sol on pixels 1 and 9; counters wrap so the next quad gets sol again.
- Reset mid-SEND (rst=0 at lane 1 with 2 quads queued) -> the next edge gives out_valid=0, full=0, overflow=0; a following quad emits from lane 0 with sol=1.
- With BICUBIC_SER_FRAME_CNT_EN defined, 3 frames streamed -> frame_cnt=3; with the macro undefined, the build has no frame_cnt port.
